decode_stage: RTL and testbench

//  Registered instruction-decode stage between instruction fetch and ext_unit/ALU. Accepts 32-bit RV32I

---
 rtl/decode_stage.sv | 148 ++++++++++++++
 tb/tb_decode_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage with a two-entry skid buffer.
// Decodes ImmType/illegal at capture; all outputs come from flops.
module decode_stage #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [PC_WIDTH-1:0] pc_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [24:0]         imm,
  output logic [1:0]          ImmType,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [6:0]          opcode,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] IT_I = 2'b00;
  localparam logic [1:0] IT_S = 2'b01;
  localparam logic [1:0] IT_B = 2'b10;
  localparam logic [1:0] IT_U = 2'b11;

  typedef struct packed {
    logic [31:0]         ins;
    logic [PC_WIDTH-1:0] pc;
    logic [1:0]          itype;
    logic                ill;
  } ent_t;

  ent_t main_q;
  ent_t skid_q;
  logic main_v;
  logic skid_v;
  ent_t nxt;
  logic acc;
  logic cons;
  logic [6:0] op;

  assign acc  = in_valid & ~skid_v;
  assign cons = main_v & out_ready;
  assign op   = instr[6:0];

  // Decode the incoming word into a buffer entry
  always_comb begin
    nxt.ins   = instr;
    nxt.pc    = pc_in;
    nxt.itype = IT_I;
    nxt.ill   = 1'b0;
    unique case (1'b1)
      (op == OP_R),
      (op == OP_IMM),
      (op == OP_LOAD),
      (op == OP_JALR),
      (op == OP_SYS): begin
        nxt.itype = IT_I;
        nxt.ill   = 1'b0;
      end
      (op == OP_STORE): begin
        nxt.itype = IT_S;
        nxt.ill   = 1'b0;
      end
      (op == OP_BR): begin
        nxt.itype = IT_B;
        nxt.ill   = 1'b0;
      end
      (op == OP_LUI),
      (op == OP_AUIPC): begin
        nxt.itype = IT_U;
        nxt.ill   = 1'b0;
      end
      (op == OP_JAL): begin
        nxt.itype = IT_I;
        nxt.ill   = 1'b1;
      end
      default: begin
        nxt.itype = IT_I;
        nxt.ill   = 1'b1;
      end
    endcase
  end

  // Main/skid entry update; flush clears valids, data holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (cons) begin
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        if (acc) begin
          skid_q <= nxt;
          skid_v <= 1'b1;
        end else begin
          skid_v <= 1'b0;
        end
      end else if (acc) begin
        main_q <= nxt;
        main_v <= 1'b1;
      end else begin
        main_v <= 1'b0;
      end
    end else if (acc) begin
      if (main_v) begin
        skid_q <= nxt;
        skid_v <= 1'b1;
      end else begin
        main_q <= nxt;
        main_v <= 1'b1;
      end
    end
  end

  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign imm       = main_q.ins[31:7];
  assign rs1       = main_q.ins[19:15];
  assign rs2       = main_q.ins[24:20];
  assign rd        = main_q.ins[11:7];
  assign opcode    = main_q.ins[6:0];
  assign ImmType   = main_q.itype;
  assign illegal   = main_q.ill;
  assign pc_out    = main_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage.
// Reference model: FIFO queue of depth 2 plus opcode table.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [24:0] imm;
  logic [1:0]  ImmType;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode;
  logic [31:0] pc_out;
  logic        illegal;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } item_t;

  item_t       q[$];
  logic [31:0] mdl_log[$];
  logic [31:0] dut_log[$];
  bit          m_acc, m_cons;

  decode_stage #(.PC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .ImmType(ImmType),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .opcode(opcode), .pc_out(pc_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {illegal, ImmType} from the opcode table
  function automatic logic [2:0] ref_dec(input logic [31:0] w);
    case (w[6:0])
      7'h33, 7'h13, 7'h03, 7'h67, 7'h73: return 3'b000;
      7'h23:                             return 3'b001;
      7'h63:                             return 3'b010;
      7'h37, 7'h17:                      return 3'b011;
      default:                           return 3'b100;
    endcase
  endfunction

  // Queue model of the stage, advanced on every edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_acc  = in_valid && (q.size() < 2);
      m_cons = (q.size() > 0) && out_ready;
      if (out_valid && out_ready) dut_log.push_back(pc_out);
      if (m_cons) begin
        mdl_log.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (m_acc) q.push_back('{instr, pc_in});
    end
  end

  task automatic step(input bit iv, input logic [31:0] w,
                      input logic [31:0] p, input bit ordy,
                      input bit fl);
    in_valid  = iv;
    instr     = w;
    pc_in     = p;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 4; c++) step(0, '0, '0, 1, 0);
    mdl_log.delete();
    dut_log.delete();
  endtask

  task automatic test_reset();
    logic [31:0] w;
    rst_n = 1'b0;
    in_valid = 1'b1;
    instr = 32'h00500093;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    nvec++;
    if ({imm, ImmType, illegal, pc_out} !== '0) begin
      nerr++; $display("FAIL reset_data got imm=%h it=%b ill=%b pc=%h exp 0",
                       imm, ImmType, illegal, pc_out);
    end
    #4 rst_n = 1'b1;
    w = 32'h00500093;
    step(1, w, 32'h0, 0, 0);
    nvec++;
    if (out_valid !== 1'b1) begin
      nerr++; $display("FAIL addi_valid got %b exp 1", out_valid);
    end
    nvec++;
    if ({ImmType, illegal, rd, rs1} !== {2'b00, 1'b0, 5'd1, 5'd0}) begin
      nerr++; $display("FAIL addi_fields got it=%b ill=%b rd=%0d rs1=%0d exp 00 0 1 0",
                       ImmType, illegal, rd, rs1);
    end
    nvec++;
    if (imm !== w[31:7]) begin
      nerr++; $display("FAIL addi_imm got %h exp %h", imm, w[31:7]);
    end
    drain();
  endtask

  task automatic test_format();
    logic [31:0] v[5];
    logic [2:0]  e[5];
    logic [31:0] w;
    v = '{32'h00112223, 32'h00208463, 32'h123450B7,
          32'h0000006F, 32'hFFFFFFFF};
    e = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b100};
    for (int k = 0; k < 5; k++) begin
      w = v[k];
      step(1, w, 32'h100 + 4 * k, 1, 0);
      nvec++;
      if ({illegal, ImmType} !== e[k]) begin
        nerr++; $display("FAIL fmt_%0d got ill=%b it=%b exp %b", k,
                         illegal, ImmType, e[k]);
      end
      nvec++;
      if ({imm, rs1, rs2, rd, opcode} !==
          {w[31:7], w[19:15], w[24:20], w[11:7], w[6:0]}) begin
        nerr++; $display("FAIL fmt_fields_%0d got imm=%h op=%h", k, imm, opcode);
      end
      if (k == 2) begin
        nvec++;
        if (imm[24:5] !== 20'h12345) begin
          nerr++; $display("FAIL lui_imm got %h exp 12345", imm[24:5]);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int  i;
    bit  r;
    i = 0;
    for (int c = 0; c < 4; c++) begin
      r = q.size() < 2;
      step(1, 32'h13, 4 * i, 0, 0);
      if (r) i++;
    end
    nvec++;
    if (i != 2 || in_ready !== 1'b0) begin
      nerr++; $display("FAIL bp_full got accepts=%0d in_ready=%b exp 2 0", i, in_ready);
    end
    nvec++;
    if (out_valid !== 1'b1 || pc_out !== 32'd0) begin
      nerr++; $display("FAIL bp_hold got v=%b pc=%h exp 1 0", out_valid, pc_out);
    end
    for (int c = 0; c < 20 && dut_log.size() < 4; c++) begin
      r = q.size() < 2;
      step(i < 4, 32'h13, 4 * i, 1, 0);
      if (r && i < 4) i++;
    end
    nvec++;
    if (dut_log.size() != 4) begin
      nerr++; $display("FAIL bp_count got %0d exp 4", dut_log.size());
    end
    for (int k = 0; k < dut_log.size(); k++) begin
      nvec++;
      if (dut_log[k] !== 32'(4 * k)) begin
        nerr++; $display("FAIL bp_order_%0d got %h exp %h", k, dut_log[k], 4 * k);
      end
    end
    drain();
  endtask

  task automatic test_throughput();
    for (int k = 0; k < 16; k++) begin
      step(1, $urandom, 32'h200 + 4 * k, 1, 0);
      nvec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 ||
          pc_out !== 32'(32'h200 + 4 * k)) begin
        nerr++; $display("FAIL tput_%0d got rdy=%b v=%b pc=%h exp 1 1 %h", k,
                         in_ready, out_valid, pc_out, 32'h200 + 4 * k);
      end
    end
    step(0, '0, '0, 1, 0);
    nvec++;
    if (dut_log.size() != 16) begin
      nerr++; $display("FAIL tput_count got %0d exp 16", dut_log.size());
    end
    drain();
  endtask

  task automatic test_flush();
    step(1, 32'h13, 32'h0, 0, 0);
    step(1, 32'h13, 32'h4, 0, 0);
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++; $display("FAIL flush_full got in_ready=%b exp 0", in_ready);
    end
    step(1, 32'h13, 32'h8, 0, 1);
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL flush_clear got v=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
    for (int c = 0; c < 4; c++) step(0, '0, '0, 1, 0);
    nvec++;
    if (dut_log.size() != 0) begin
      nerr++; $display("FAIL flush_leak got %0d outputs exp 0", dut_log.size());
    end
    drain();
  endtask

  task automatic test_async_reset();
    step(1, 32'h13, 32'h10, 0, 0);
    step(1, 32'h13, 32'h14, 0, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nerr++; $display("FAIL areset got v=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
    #2 rst_n = 1'b1;
    step(1, 32'h00500093, 32'h40, 0, 0);
    nvec++;
    if (out_valid !== 1'b1 || pc_out !== 32'h40) begin
      nerr++; $display("FAIL areset_resume got v=%b pc=%h exp 1 40", out_valid, pc_out);
    end
    drain();
  endtask

  task automatic test_random();
    logic [2:0] d;
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
      nvec++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        nerr++; $display("FAIL rnd_hs_%0d got v=%b rdy=%b exp %b %b", c,
                         out_valid, in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        d = ref_dec(q[0].ins);
        nvec++;
        if ({pc_out, imm, rs1, rs2, rd, opcode, illegal, ImmType} !==
            {q[0].pc, q[0].ins[31:7], q[0].ins[19:15], q[0].ins[24:20],
             q[0].ins[11:7], q[0].ins[6:0], d}) begin
          nerr++; $display("FAIL rnd_data_%0d got pc=%h imm=%h ill=%b it=%b exp pc=%h ins=%h dec=%b",
                           c, pc_out, imm, illegal, ImmType, q[0].pc, q[0].ins, d);
        end
      end
    end
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 1, 0);
    nvec++;
    if (dut_log != mdl_log) begin
      nerr++; $display("FAIL rnd_order got %0d outputs exp %0d",
                       dut_log.size(), mdl_log.size());
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_format();
    test_backpressure();
    test_throughput();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
